// File: rtl/ppu_reg_if.sv
// CPU-facing PPU register block: $2000-$2007 decode, status flags, scroll and
// VRAM address latches, OAM/VRAM access strobes and the buffered $2007 read path.
module ppu_reg_if #(
    parameter int VADDR_W = 14
) (
    input  logic               PPU_SLOW_CLOCK,
    input  logic               RST,
    input  logic [2:0]         CPUA,
    input  logic [7:0]         CPUDI,
    output logic [7:0]         CPUDO,
    input  logic               RW,
    input  logic               CS,
    input  logic               VBLANK_START,
    input  logic               VBLANK_END,
    input  logic               SPR0_HIT,
    input  logic               SPR_OVF,
    output logic               NMI,
    output logic [7:0]         PPUCTL,
    output logic [7:0]         PPUMASK,
    output logic [7:0]         SCROLL_X,
    output logic [7:0]         SCROLL_Y,
    output logic [7:0]         OAM_ADDR,
    output logic [7:0]         OAM_WDATA,
    output logic               OAM_WE,
    input  logic [7:0]         OAM_RDATA,
    output logic [VADDR_W-1:0] VRAM_ADDR,
    output logic [7:0]         VRAM_WDATA,
    output logic               VRAM_WE,
    output logic               VRAM_RE,
    input  logic [7:0]         VRAM_RDATA
);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;

    fill_state_t        state_reg;
    logic [7:0]         cpudo_reg;
    logic [7:0]         ppuctl_reg;
    logic [7:0]         ppumask_reg;
    logic [7:0]         scroll_x_reg;
    logic [7:0]         scroll_y_reg;
    logic [7:0]         iol_reg;
    logic [7:0]         oa_reg;
    logic [7:0]         rb_reg;
    logic [VADDR_W-1:0] v_reg;
    logic               nmi_reg;
    logic               vbl_reg;
    logic               s0_reg;
    logic               ovf_reg;
    logic               w_reg;

    logic               wr;
    logic               rd;
    logic [7:0]         wr_sel;
    logic [7:0]         rd_sel;
    logic [VADDR_W-1:0] v_step;
    logic [7:0]         status;
    logic [7:0]         rd_data;

    assign wr = CS & ~RW;
    assign rd = CS & RW;

    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
        assign wr_sel[gi] = wr & (CPUA == 3'(gi));
        assign rd_sel[gi] = rd & (CPUA == 3'(gi));
    end

    assign v_step = ppuctl_reg[2] ? VADDR_W'(32) : VADDR_W'(1);

    // A vblank edge landing on the status read is reported as clear; the flag still sets.
    assign status = {vbl_reg & ~VBLANK_START, s0_reg, ovf_reg, iol_reg[4:0]};

    always_comb begin
        rd_data = iol_reg;
        case (CPUA)
            3'd2:    rd_data = status;
            3'd4:    rd_data = OAM_RDATA;
            3'd7:    rd_data = (state_reg == FILL) ? VRAM_RDATA : rb_reg;
            default: rd_data = iol_reg;
        endcase
    end

    // Strobes are issued in the access cycle so a fetch's data is back in the very next cycle.
    assign OAM_WE     = wr_sel[4] & RST;
    assign OAM_WDATA  = OAM_WE ? CPUDI : 8'h00;
    assign OAM_ADDR   = oa_reg;
    assign VRAM_WE    = wr_sel[7] & RST;
    assign VRAM_RE    = rd_sel[7] & RST;
    assign VRAM_WDATA = VRAM_WE ? CPUDI : 8'h00;
    assign VRAM_ADDR  = v_reg;

    assign CPUDO    = cpudo_reg;
    assign NMI      = nmi_reg;
    assign PPUCTL   = ppuctl_reg;
    assign PPUMASK  = ppumask_reg;
    assign SCROLL_X = scroll_x_reg;
    assign SCROLL_Y = scroll_y_reg;

    always_ff @(posedge PPU_SLOW_CLOCK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            cpudo_reg    <= 8'h00;
            ppuctl_reg   <= 8'h00;
            ppumask_reg  <= 8'h00;
            scroll_x_reg <= 8'h00;
            scroll_y_reg <= 8'h00;
            iol_reg      <= 8'h00;
            oa_reg       <= 8'h00;
            rb_reg       <= 8'h00;
            v_reg        <= '0;
            nmi_reg      <= 1'b0;
            vbl_reg      <= 1'b0;
            s0_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            w_reg        <= 1'b0;
        end else begin
            nmi_reg <= ppuctl_reg[7] & vbl_reg;

            if (VBLANK_END) begin
                vbl_reg <= 1'b0;
                s0_reg  <= 1'b0;
                ovf_reg <= 1'b0;
            end else begin
                if (VBLANK_START)   vbl_reg <= 1'b1;
                else if (rd_sel[2]) vbl_reg <= 1'b0;
                if (SPR0_HIT)       s0_reg  <= 1'b1;
                if (SPR_OVF)        ovf_reg <= 1'b1;
            end

            if (rd)        cpudo_reg   <= rd_data;
            if (wr)        iol_reg     <= CPUDI;
            if (wr_sel[0]) ppuctl_reg  <= CPUDI;
            if (wr_sel[1]) ppumask_reg <= CPUDI;

            if (wr_sel[3])      oa_reg <= CPUDI;
            else if (wr_sel[4]) oa_reg <= oa_reg + 8'd1;

            // $2005 and $2006 share one first/second-write toggle.
            if (rd_sel[2])                   w_reg <= 1'b0;
            else if (wr_sel[5] | wr_sel[6])  w_reg <= ~w_reg;

            if (wr_sel[5]) begin
                if (!w_reg) scroll_x_reg <= CPUDI;
                else        scroll_y_reg <= CPUDI;
            end

            if (wr_sel[6]) begin
                if (!w_reg) v_reg <= {CPUDI[VADDR_W-9:0], v_reg[7:0]};
                else        v_reg <= {v_reg[VADDR_W-1:8], CPUDI};
            end else if (wr_sel[7] | rd_sel[7]) begin
                v_reg <= v_reg + v_step;
            end

            case (state_reg)
                IDLE: begin
                    if (rd_sel[7]) state_reg <= FILL;
                end
                FILL: begin
                    rb_reg <= VRAM_RDATA;
                    if (!rd_sel[7]) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ppu_reg_if.md
PPU_REG_IF -- requirements
Module: ppu_reg_if

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low: port RST asserted at 0; every other port SHALL be synchronous to the rising edge of PPU_SLOW_CLOCK.
REQ-002 The ports SHALL be:
- PPU_SLOW_CLOCK  in  1  clock.
- RST  in  1  async reset, active-low.
- CPUA  in  3  register select, 0-7 = $2000-$2007.
- CPUDI  in  8  CPU write data.
- CPUDO  out  8  CPU read data, registered.
- RW  in  1  1 = read, 0 = write.
- CS  in  1  access strobe; one access per cycle with CS=1.
- VBLANK_START  in  1  one-cycle pulse, first vblank line.
- VBLANK_END  in  1  one-cycle pulse, pre-render line.
- SPR0_HIT  in  1  one-cycle pulse.
- SPR_OVF  in  1  one-cycle pulse.
- NMI  out  1  interrupt to CPU, active-high level.
- PPUCTL  out  8  control register.
- PPUMASK  out  8  mask register.
- SCROLL_X  out  8  fine and coarse X scroll.
- SCROLL_Y  out  8  fine and coarse Y scroll.
- OAM_ADDR  out  8  OAM address.
- OAM_WDATA  out  8  OAM write data.
- OAM_WE  out  1  OAM write strobe.
- OAM_RDATA  in  8  OAM read data at OAM_ADDR, combinational.
- VRAM_ADDR  out  14  VRAM address.
- VRAM_WDATA  out  8  VRAM write data.
- VRAM_WE  out  1  VRAM write strobe.
- VRAM_RE  out  1  VRAM read strobe.
- VRAM_RDATA  in  8  valid exactly 1 cycle after VRAM_RE.
REQ-003 Parameter VADDR_W, default 14: width of the VRAM address.

Function
REQ-004 Write to $2000 SHALL load PPUCTL; write to $2001 SHALL load PPUMASK; both visible the next cycle.
REQ-005 Every CPU write SHALL also load an 8-bit open-bus latch IOL with CPUDI.
REQ-006 NMI SHALL be registered and SHALL equal PPUCTL[7] AND VBL, one cycle after either term changes. Setting PPUCTL[7] while VBL=1 SHALL raise NMI.
REQ-007 Status flags VBL, S0, OVF:
- VBLANK_START sets VBL.
- SPR0_HIT sets S0.
- SPR_OVF sets OVF.
- VBLANK_END clears all three and takes priority over simultaneous set pulses.
REQ-008 Read of $2002 SHALL return {VBL, S0, OVF, IOL[4:0]}, then clear VBL and clear the write toggle W. If VBLANK_START arrives in the same cycle, the read SHALL return VBL=0 and VBL SHALL end up set (set wins).
REQ-009 Write to $2003 SHALL load the internal OAM address register OA.
REQ-010 Write to $2004 SHALL pulse OAM_WE for 1 cycle with OAM_ADDR=OA and OAM_WDATA=CPUDI, then increment OA modulo 256 (255 -> 0).
REQ-011 Read of $2004 SHALL return OAM_RDATA sampled at OA and SHALL NOT increment OA.
REQ-012 Write to $2005:
- W=0: load SCROLL_X and set W.
- W=1: load SCROLL_Y and clear W.
REQ-013 Write to $2006:
- W=0: load V[13:8] from CPUDI[5:0] and set W.
- W=1: load V[7:0] and clear W.
$2005 and $2006 SHALL share the same W.
REQ-014 Write to $2007 SHALL pulse VRAM_WE for 1 cycle with VRAM_ADDR=V and VRAM_WDATA=CPUDI, then set V = V + (PPUCTL[2] ? 32 : 1) modulo 2^14.
REQ-015 The $2007 read FSM SHALL have states IDLE and FILL.
- In IDLE, a $2007 read returns read buffer RB, pulses VRAM_RE with VRAM_ADDR=V, increments V per REQ-014, and moves to FILL.
- In FILL, RB loads VRAM_RDATA and the FSM returns to IDLE.
REQ-016 A $2007 read in FILL state SHALL return VRAM_RDATA (bypass) instead of RB and SHALL start a new fetch (stay in FILL).
REQ-017 CPUDO SHALL update only on read cycles, one cycle after CS&RW, and SHALL hold otherwise.
REQ-018 Reads of write-only registers ($2000, $2001, $2003, $2005, $2006) SHALL return IOL. Writes to $2002 SHALL only update IOL.
REQ-019 VRAM_ADDR SHALL present V whenever no strobe is active. OAM_ADDR SHALL always present OA.
REQ-020 With CS=0, no register, flag other than VBL/S0/OVF, or strobe SHALL change.

Reset
REQ-021 While RST=0, the following SHALL be 0:
- outputs: CPUDO, NMI, PPUCTL, PPUMASK, SCROLL_X, SCROLL_Y, OAM_ADDR, OAM_WDATA, OAM_WE, VRAM_ADDR, VRAM_WDATA, VRAM_WE, VRAM_RE.
- internal state: IOL, OA, V, RB, W, VBL, S0, OVF.
The FSM SHALL be in IDLE.
REQ-022 Reset asserted mid-fetch SHALL abort the fetch; the first $2007 read after reset SHALL return 00.

Verification
REQ-023 Write $2000=80 then pulse VBLANK_START -> NMI=1 one cycle later. Read $2002 -> CPUDO=80 | IOL[4:0]; NMI=0 the next cycle.
REQ-024 Write $2006=21, $2006=08, then $2007=AA, $2007=BB -> VRAM_WE pulses at addresses 2108 and 2109; with PPUCTL[2]=1 the second address is 2128.
REQ-025 Preload VRAM 2000=11, 2001=22. Write $2006=20,00; read $2007 twice 3 cycles apart -> CPUDO=00 then 11. An immediately following back-to-back read -> 22 (bypass).
REQ-026 Write $2003=FF, then $2004=5A, $2004=6B -> OAM writes at FF and 00. Read $2004 -> OAM[01], OA unchanged.
REQ-027 Write $2005=10, read $2002, write $2005=20 -> SCROLL_X=20, SCROLL_Y unchanged (W was cleared).
REQ-028 Pulse VBLANK_START and read $2002 in the same cycle -> CPUDO[7]=0, VBL=1 afterwards. Pulse VBLANK_END together with SPR0_HIT -> S0=0.
